// File: rtl/ysyx_25040101_mem_pkg.sv
// Shared types for the IFU/LSU data-memory arbiter: FSM states, owners, access size codes.
package ysyx_25040101_mem_pkg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned SIZE_W     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        RSP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam logic [SIZE_W-1:0] SZ_1B = 2'd0;
    localparam logic [SIZE_W-1:0] SZ_2B = 2'd1;
    localparam logic [SIZE_W-1:0] SZ_4B = 2'd2;

    // Size code 3 has no encoding and never reaches memory.
    function automatic logic size_illegal(input logic [SIZE_W-1:0] size);
        return size == 2'd3;
    endfunction

endpackage

// File: rtl/ysyx_25040101_mem_arbiter_if.sv
// IFU, LSU and memory-backend bus signals of the arbiter; master = arbiter side, slave = environment.
interface ysyx_25040101_mem_arbiter_if
    import ysyx_25040101_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
) ();

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_rsp_valid;
    logic [DATA_W-1:0] ifu_rsp_data;
    logic              ifu_rsp_err;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic              lsu_wen;
    logic [SIZE_W-1:0] lsu_size;
    logic              lsu_sext;
    logic              lsu_rsp_valid;
    logic [DATA_W-1:0] lsu_rsp_data;
    logic              lsu_rsp_err;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wen;
    logic [SIZE_W-1:0] mem_size;
    logic              mem_sext;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;
    logic              mem_rsp_err;

    modport master (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wdata, lsu_wen, lsu_size, lsu_sext,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
        output mem_req_valid, mem_addr, mem_wdata, mem_wen, mem_size, mem_sext
    );

    modport slave (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wdata, lsu_wen, lsu_size, lsu_sext,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
        input  mem_req_valid, mem_addr, mem_wdata, mem_wen, mem_size, mem_sext
    );

endinterface

// File: rtl/ysyx_25040101_rr_arb2.sv
// Two-way round-robin picker: bit 0 = IFU, bit 1 = LSU; a tie goes to the side not granted last.
module ysyx_25040101_rr_arb2
    import ysyx_25040101_mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant == OWN_LSU) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ysyx_25040101_mem_arbiter.sv
// Shares one data-memory port between IFU and LSU, one transaction outstanding, round-robin grant.
// Optional watchdog on stuck memory transactions: define YSYX_25040101_ARB_TIMEOUT_EN.
module ysyx_25040101_mem_arbiter
    import ysyx_25040101_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = MEM_ADDR_W,
    parameter int unsigned DATA_W      = MEM_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input logic                          clk,
    input logic                          rst_n,
    ysyx_25040101_mem_arbiter_if.master  bus
);

    state_e            state_q, state_d;
    owner_e            owner_q, last_grant_q;
    logic [1:0]        grant;
    logic              accept;
    logic              illegal_q;
    logic              timeout_hit;

    logic              mem_req_valid_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_wen_q;
    logic [SIZE_W-1:0] mem_size_q;
    logic              mem_sext_q;

    logic              ifu_req_ready_c, lsu_req_ready_c;
    logic              rsp_load;
    logic [DATA_W-1:0] rsp_data_n;
    logic              rsp_err_n;

    logic              ifu_rsp_valid_q, lsu_rsp_valid_q;
    logic [DATA_W-1:0] ifu_rsp_data_q, lsu_rsp_data_q;
    logic              ifu_rsp_err_q, lsu_rsp_err_q;

    ysyx_25040101_rr_arb2 u_rr_arb2 (
        .req        ({bus.lsu_req_valid, bus.ifu_req_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign accept = (state_q == IDLE) && (|grant) && rst_n;

`ifdef YSYX_25040101_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             busy_c;

    assign busy_c      = (state_q == REQ) || (state_q == RESP);
    assign timeout_hit = busy_c && (cnt_q == CNT_W'(TIMEOUT_CYC));

    // Saturating watchdog, restarted on every accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (busy_c && !timeout_hit) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, combinational grants and the response value to capture on entry to RSP.
    always_comb begin
        state_d         = state_q;
        ifu_req_ready_c = 1'b0;
        lsu_req_ready_c = 1'b0;
        rsp_load        = 1'b0;
        rsp_data_n      = '0;
        rsp_err_n       = 1'b0;
        unique case (state_q)
            IDLE: begin
                ifu_req_ready_c = grant[0] && rst_n;
                lsu_req_ready_c = grant[1] && rst_n;
                if (|grant) state_d = REQ;
            end
            REQ: begin
                if (illegal_q || timeout_hit) begin
                    state_d   = RSP;
                    rsp_load  = 1'b1;
                    rsp_err_n = 1'b1;
                end else if (bus.mem_req_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.mem_rsp_valid) begin
                    state_d    = RSP;
                    rsp_load   = 1'b1;
                    rsp_data_n = mem_wen_q ? '0 : bus.mem_rsp_data;
                    rsp_err_n  = bus.mem_rsp_err;
                end else if (timeout_hit) begin
                    state_d   = RSP;
                    rsp_load  = 1'b1;
                    rsp_err_n = 1'b1;
                end
            end
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch: fields captured on accept, valid held for the whole REQ phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q         <= OWN_IFU;
            last_grant_q    <= OWN_LSU;
            illegal_q       <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_wen_q       <= 1'b0;
            mem_size_q      <= '0;
            mem_sext_q      <= 1'b0;
        end else if (accept) begin
            if (grant[0]) begin
                owner_q         <= OWN_IFU;
                last_grant_q    <= OWN_IFU;
                illegal_q       <= 1'b0;
                mem_req_valid_q <= 1'b1;
                mem_addr_q      <= bus.ifu_addr;
                mem_wdata_q     <= '0;
                mem_wen_q       <= 1'b0;
                mem_size_q      <= SZ_4B;
                mem_sext_q      <= 1'b0;
            end else begin
                owner_q         <= OWN_LSU;
                last_grant_q    <= OWN_LSU;
                illegal_q       <= size_illegal(bus.lsu_size);
                mem_req_valid_q <= !size_illegal(bus.lsu_size);
                mem_addr_q      <= bus.lsu_addr;
                mem_wdata_q     <= bus.lsu_wdata;
                mem_wen_q       <= bus.lsu_wen;
                mem_size_q      <= bus.lsu_size;
                mem_sext_q      <= bus.lsu_sext;
            end
        end else if (state_d != REQ) begin
            mem_req_valid_q <= 1'b0;
        end
    end

    // Owner's response registers; valid is a single-cycle pulse during RSP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifu_rsp_valid_q <= 1'b0;
            ifu_rsp_data_q  <= '0;
            ifu_rsp_err_q   <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
            lsu_rsp_data_q  <= '0;
            lsu_rsp_err_q   <= 1'b0;
        end else begin
            ifu_rsp_valid_q <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
            if (rsp_load) begin
                if (owner_q == OWN_IFU) begin
                    ifu_rsp_valid_q <= 1'b1;
                    ifu_rsp_data_q  <= rsp_data_n;
                    ifu_rsp_err_q   <= rsp_err_n;
                end else begin
                    lsu_rsp_valid_q <= 1'b1;
                    lsu_rsp_data_q  <= rsp_data_n;
                    lsu_rsp_err_q   <= rsp_err_n;
                end
            end
        end
    end

    assign bus.ifu_req_ready = ifu_req_ready_c;
    assign bus.lsu_req_ready = lsu_req_ready_c;
    assign bus.ifu_rsp_valid = ifu_rsp_valid_q;
    assign bus.ifu_rsp_data  = ifu_rsp_data_q;
    assign bus.ifu_rsp_err   = ifu_rsp_err_q;
    assign bus.lsu_rsp_valid = lsu_rsp_valid_q;
    assign bus.lsu_rsp_data  = lsu_rsp_data_q;
    assign bus.lsu_rsp_err   = lsu_rsp_err_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_wen       = mem_wen_q;
    assign bus.mem_size      = mem_size_q;
    assign bus.mem_sext      = mem_sext_q;

endmodule
